ras_stack: RTL and testbench
============================

// Module: ras_stack
// PURPOSE
// - Return address stack for the fetch predictor. Pushes the link PC38 on BTB JUMP_L/INDIRECT_L hits
//   and pops on BTB RET/RET_L hits; the top of stack drives the ret_pc38 fast-redirect target.
// - Exposes ras_index/ras_count every cycle for BCB checkpointing.
// - Accepts a pointer restore from the BCB on a branch mispredict or a restart.
// PARAMETERS
// - RAS_ENTRIES      16  stack depth; power of 2 (corep::RAS_ENTRIES)
// - LOG_RAS_ENTRIES  4   index width (corep::LOG_RAS_ENTRIES)
// PORTS
// - CLK                    in   1    clock; all state updates on the rising edge
// - RST                    in   1    reset; synchronous, active-high
// - push_valid             in   1    push push_pc38 this cycle
// - push_pc38              in   38   return address to push (corep::PC38_t)
// - pop_valid              in   1    pop the top entry this cycle
// - restore_valid          in   1    restore the pointers from the BCB
// - restore_ras_index      in   4    restored index (corep::RAS_idx_t)
// - restore_ras_count      in   5    restored count (corep::RAS_cnt_t), 0..16
// - ret_pc38               out  38   entry[ras_index]; combinational read of registered state
// - ret_valid              out  1    (ras_count != 0)
// - ras_index              out  4    current top-of-stack index, for the BCB snapshot
// - ras_count              out  5    current valid-entry count, saturates at RAS_ENTRIES
// BEHAVIOUR
// - Reset: ras_index=0, ras_count=0, all entries=38'h0.
//   So ret_pc38=0 and ret_valid=0 in the cycle after RST falls.
// - ras_index points at the most recently pushed entry. Index arithmetic is mod RAS_ENTRIES.
// - Update priority per cycle: RST > restore_valid > push/pop.
// - Restore: index<=restore_ras_index; count<=restore_ras_count (values >16 clamp to 16).
//   - Entry contents are untouched; push/pop in the same cycle are ignored.
// - Push only: index<=index+1; entry[index+1]<=push_pc38; count<=min(count+1,16).
//   - At count==16 the oldest entry is overwritten by the wrap and count stays 16.
// - Pop only, count>0: index<=index-1; count<=count-1. Entries are not cleared.
// - Pop only, count==0: no state change (underflow is ignored).
// - Push+pop same cycle (RET_L coroutine swap): entry[index]<=push_pc38; index unchanged.
//   - count<=max(count,1).
// - Latency: a push/pop/restore in cycle N is visible on ret_pc38, ras_index and ras_count in N+1.
//   The outputs have no same-cycle bypass.
// - Snapshot semantics: the ras_index/ras_count outputs are the pre-update state of the cycle.
//   The BCB captures these together with the predicting access.
// - Reset mid-operation: RST wins over every input. All entries clear on the next edge.
// - No back-pressure: every push, pop and restore is accepted in the cycle it is presented.
// STRUCTURE
// - corep already provides PC38_t, RAS_idx_t, RAS_cnt_t, RAS_ENTRIES, LOG_RAS_ENTRIES and BCB_entry_t.
//   No new package types are needed.
// - No sub-module. Inline flop array RAS_ENTRIES x 38b with one write port and one read port.
//   Index and count registers sit beside the array.
// - Next-state logic is a single always_comb with the priority above; one always_ff holds all state.
// TESTING
// - Reset, then push 38'h100, 38'h200, 38'h300 on consecutive cycles, then pop 3x.
//   Required: ret_pc38 reads 300, 200, 100 on the pops; count goes 3->0; ret_valid=0 at the end.
// - Push 17 values 38'h1..38'h11.
//   Required: count=16; index=1 (reset 0, +17 mod 16); ret_pc38=11; then 16 pops return 11..2.
// - Pop at count==0.
//   Required: index, count and ret_pc38 are unchanged and ret_valid stays 0.
// - Push 38'hA, then push+pop with 38'hB in the same cycle.
//   Required: index=1, count=1, ret_pc38=B; a following pop gives count=0.
// - Snapshot (index=2, count=2), push 3x, then restore with that snapshot in the same cycle as a pop.
//   Required: index=2, count=2, ret_pc38 = the value originally at entry 2; the pop is ignored.
// - Assert RST while push_valid=1 at count=5.
//   Required: next cycle index=0, count=0, ret_pc38=0; the push is dropped.

Source files
------------

// File: rtl/ras_stack_pkg.sv
// Shared types and sizing for the return address stack.
// Counts are one bit wider than indices so a full stack (RAS_ENTRIES) is representable.
package ras_stack_pkg;

    localparam int RAS_ENTRIES     = 16;
    localparam int LOG_RAS_ENTRIES = 4;

    typedef logic [37:0]                pc38_t;
    typedef logic [LOG_RAS_ENTRIES-1:0] ras_idx_t;
    typedef logic [LOG_RAS_ENTRIES:0]   ras_cnt_t;

    localparam ras_cnt_t RAS_CNT_MAX = ras_cnt_t'(RAS_ENTRIES);

    // Per-cycle operation after applying restore > push/pop priority.
    typedef enum logic [2:0] {
        RAS_OP_IDLE,
        RAS_OP_RESTORE,
        RAS_OP_SWAP,
        RAS_OP_PUSH,
        RAS_OP_POP
    } ras_op_e;

    function automatic ras_cnt_t clamp_cnt(input ras_cnt_t c);
        return (c > RAS_CNT_MAX) ? RAS_CNT_MAX : c;
    endfunction

endpackage

// File: rtl/ras_stack_if.sv
// Predictor <-> RAS signal bundle. There is no back-pressure: push_valid, pop_valid and
// restore_valid are single-cycle strobes that are always accepted on the edge they are sampled.
interface ras_stack_if;
    import ras_stack_pkg::*;

    logic     push_valid;
    pc38_t    push_pc38;
    logic     pop_valid;
    logic     restore_valid;
    ras_idx_t restore_ras_index;
    ras_cnt_t restore_ras_count;

    pc38_t    ret_pc38;
    logic     ret_valid;
    ras_idx_t ras_index;
    ras_cnt_t ras_count;

    modport master (
        output push_valid, push_pc38, pop_valid,
        output restore_valid, restore_ras_index, restore_ras_count,
        input  ret_pc38, ret_valid, ras_index, ras_count
    );

    modport slave (
        input  push_valid, push_pc38, pop_valid,
        input  restore_valid, restore_ras_index, restore_ras_count,
        output ret_pc38, ret_valid, ras_index, ras_count
    );

endinterface

// File: rtl/ras_stack.sv
// Circular return address stack: index points at the newest entry, count saturates at depth.
// Outputs are the registered state of the cycle, so the BCB snapshot is always pre-update.
module ras_stack
    import ras_stack_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    ras_stack_if.slave   rif
);

    pc38_t    entry_q [RAS_ENTRIES];
    ras_idx_t idx_q, idx_d;
    ras_cnt_t cnt_q, cnt_d;
    logic     wr_en;
    ras_idx_t wr_addr;
    ras_op_e  op;

    // Underflowing pops collapse to idle so they cannot disturb the pointers.
    always_comb begin
        op = RAS_OP_IDLE;
        if (rif.restore_valid) begin
            op = RAS_OP_RESTORE;
        end else if (rif.push_valid && rif.pop_valid) begin
            op = RAS_OP_SWAP;
        end else if (rif.push_valid) begin
            op = RAS_OP_PUSH;
        end else if (rif.pop_valid && (cnt_q != '0)) begin
            op = RAS_OP_POP;
        end
    end

    always_comb begin
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        wr_en   = 1'b0;
        wr_addr = idx_q;
        unique case (op)
            RAS_OP_RESTORE: begin
                idx_d = rif.restore_ras_index;
                cnt_d = clamp_cnt(rif.restore_ras_count);
            end
            RAS_OP_SWAP: begin
                wr_en = 1'b1;
                cnt_d = (cnt_q == '0) ? ras_cnt_t'(1) : cnt_q;
            end
            RAS_OP_PUSH: begin
                idx_d   = idx_q + 1'b1;
                wr_addr = idx_q + 1'b1;
                wr_en   = 1'b1;
                cnt_d   = (cnt_q == RAS_CNT_MAX) ? RAS_CNT_MAX : cnt_q + 1'b1;
            end
            RAS_OP_POP: begin
                idx_d = idx_q - 1'b1;
                cnt_d = cnt_q - 1'b1;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q <= '0;
            cnt_q <= '0;
            for (int i = 0; i < RAS_ENTRIES; i++) begin
                entry_q[i] <= '0;
            end
        end else begin
            idx_q <= idx_d;
            cnt_q <= cnt_d;
            if (wr_en) begin
                entry_q[wr_addr] <= rif.push_pc38;
            end
        end
    end

    assign rif.ret_pc38  = entry_q[idx_q];
    assign rif.ret_valid = (cnt_q != '0);
    assign rif.ras_index = idx_q;
    assign rif.ras_count = cnt_q;

endmodule

// File: tb/tb_ras_stack.sv
// Bench for ras_stack: directed vector table, hand-written corner sequences,
// then random traffic against a circular-array reference model.
module tb_ras_stack;
  import ras_stack_pkg::*;

  logic clk;
  logic rst;
  ras_stack_if rif ();

  ras_stack u_dut (
    .clk (clk),
    .rst (rst),
    .rif (rif)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic     push;
    logic     pop;
    logic     restore;
    pc38_t    pc;
    ras_idx_t ridx;
    ras_cnt_t rcnt;
    ras_idx_t e_idx;
    ras_cnt_t e_cnt;
    pc38_t    e_ret;
    logic     e_val;
    string    name;
  } vec_t;

  vec_t vecs[$];
  logic [47:0] exp_q[$];

  // reference model state
  pc38_t m_mem [RAS_ENTRIES];
  int    m_idx;
  int    m_cnt;

  // ---------------- driver tasks ----------------
  task automatic drive(input logic push, input logic pop, input logic restore,
                       input pc38_t pc, input ras_idx_t ridx, input ras_cnt_t rcnt);
    rif.push_valid        = push;
    rif.pop_valid         = pop;
    rif.restore_valid     = restore;
    rif.push_pc38         = pc;
    rif.restore_ras_index = ridx;
    rif.restore_ras_count = rcnt;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
  endtask

  task automatic do_reset(input logic push_during);
    rst = 1'b1;
    drive(push_during, 1'b0, 1'b0, 38'h3F_DEAD_BEEF, '0, '0);
    rst = 1'b0;
  endtask

  task automatic check(input string name, input ras_idx_t e_idx, input ras_cnt_t e_cnt,
                       input pc38_t e_ret, input logic e_val);
    n_vec++;
    if (rif.ras_index !== e_idx || rif.ras_count !== e_cnt ||
        rif.ret_pc38 !== e_ret || rif.ret_valid !== e_val) begin
      n_err++;
      $display("FAIL %s: got idx=%0d cnt=%0d ret=%h valid=%0b, expected idx=%0d cnt=%0d ret=%h valid=%0b",
               name, rif.ras_index, rif.ras_count, rif.ret_pc38, rif.ret_valid,
               e_idx, e_cnt, e_ret, e_val);
    end
  endtask

  function automatic void add(input logic push, input logic pop, input logic restore,
                              input pc38_t pc, input ras_idx_t ridx, input ras_cnt_t rcnt,
                              input ras_idx_t e_idx, input ras_cnt_t e_cnt,
                              input pc38_t e_ret, input logic e_val, input string name);
    vec_t v;
    v.push = push; v.pop = pop; v.restore = restore; v.pc = pc;
    v.ridx = ridx; v.rcnt = rcnt;
    v.e_idx = e_idx; v.e_cnt = e_cnt; v.e_ret = e_ret; v.e_val = e_val;
    v.name = name;
    vecs.push_back(v);
  endfunction

  // ---------------- reference model ----------------
  task automatic model_reset();
    for (int i = 0; i < RAS_ENTRIES; i++) m_mem[i] = '0;
    m_idx = 0;
    m_cnt = 0;
  endtask

  task automatic model_step(input logic r, input logic push, input logic pop, input logic restore,
                            input pc38_t pc, input int ridx, input int rcnt);
    if (r) begin
      model_reset();
    end else if (restore) begin
      m_idx = ridx;
      m_cnt = (rcnt > RAS_ENTRIES) ? RAS_ENTRIES : rcnt;
    end else if (push && pop) begin
      m_mem[m_idx] = pc;
      m_cnt = (m_cnt < 1) ? 1 : m_cnt;
    end else if (push) begin
      m_idx = (m_idx + 1) % RAS_ENTRIES;
      m_mem[m_idx] = pc;
      m_cnt = (m_cnt + 1 > RAS_ENTRIES) ? RAS_ENTRIES : m_cnt + 1;
    end else if (pop && m_cnt > 0) begin
      m_idx = (m_idx + RAS_ENTRIES - 1) % RAS_ENTRIES;
      m_cnt = m_cnt - 1;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [47:0] exp_w;
    logic        r_push, r_pop, r_rest, r_rst;
    pc38_t       r_pc;
    int          r_ridx, r_rcnt;

    rst = 1'b0;
    rif.push_valid = 1'b0;
    rif.pop_valid = 1'b0;
    rif.restore_valid = 1'b0;
    rif.push_pc38 = '0;
    rif.restore_ras_index = '0;
    rif.restore_ras_count = '0;

    // directed table, applied back to back from reset
    add(1,0,0, 38'h100, 0,0,  1, 1, 38'h100, 1, "push_100");
    add(1,0,0, 38'h200, 0,0,  2, 2, 38'h200, 1, "push_200");
    add(1,0,0, 38'h300, 0,0,  3, 3, 38'h300, 1, "push_300");
    add(0,1,0, 38'h0,   0,0,  2, 2, 38'h200, 1, "pop_300");
    add(0,1,0, 38'h0,   0,0,  1, 1, 38'h100, 1, "pop_200");
    add(0,1,0, 38'h0,   0,0,  0, 0, 38'h0,   0, "pop_100");
    add(0,1,0, 38'h0,   0,0,  0, 0, 38'h0,   0, "pop_underflow");
    add(1,0,0, 38'hA,   0,0,  1, 1, 38'hA,   1, "push_A");
    add(1,1,0, 38'hB,   0,0,  1, 1, 38'hB,   1, "swap_B");
    add(0,1,0, 38'h0,   0,0,  0, 0, 38'h0,   0, "pop_after_swap");
    add(1,1,0, 38'hC,   0,0,  0, 1, 38'hC,   1, "swap_at_empty");
    add(0,1,0, 38'h0,   0,0, 15, 0, 38'h0,   0, "pop_after_empty_swap");
    add(0,0,1, 38'h0,   0,0,  0, 0, 38'hC,   0, "restore_zero");
    for (int k = 1; k <= 17; k++)
      add(1,0,0, pc38_t'(k), 0,0, ras_idx_t'(k % 16), ras_cnt_t'((k > 16) ? 16 : k),
          pc38_t'(k), 1, "wrap_push");
    for (int j = 1; j <= 16; j++)
      add(0,1,0, 38'h0, 0,0, ras_idx_t'((17 - j) % 16), ras_cnt_t'(16 - j),
          (j == 16) ? 38'h11 : pc38_t'(17 - j), (j != 16), "wrap_pop");
    add(0,0,1, 38'h0,   7,31, 7, 16, 38'h7, 1, "restore_clamp");
    add(1,1,1, 38'hEE,  3,4,  3, 4,  38'h3, 1, "restore_beats_swap");

    do_reset(1'b0);
    check("reset_state", 0, 0, 38'h0, 0);
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].push, vecs[i].pop, vecs[i].restore, vecs[i].pc, vecs[i].ridx, vecs[i].rcnt);
      check(vecs[i].name, vecs[i].e_idx, vecs[i].e_cnt, vecs[i].e_ret, vecs[i].e_val);
    end

    // snapshot then restore alongside a pop
    do_reset(1'b0);
    drive(1,0,0, 38'h21, 0,0);
    drive(1,0,0, 38'h22, 0,0);
    check("snap_taken", 2, 2, 38'h22, 1);
    drive(1,0,0, 38'h23, 0,0);
    drive(1,0,0, 38'h24, 0,0);
    drive(1,0,0, 38'h25, 0,0);
    check("snap_moved", 5, 5, 38'h25, 1);
    drive(0,1,1, 38'h0, 2,2);
    check("snap_restore", 2, 2, 38'h22, 1);
    drive(0,1,0, 38'h0, 0,0);
    check("snap_pop", 1, 1, 38'h21, 1);

    // reset at count 5 while pushing
    drive(1,0,0, 38'h31, 0,0);
    drive(1,0,0, 38'h32, 0,0);
    drive(1,0,0, 38'h33, 0,0);
    drive(1,0,0, 38'h34, 0,0);
    check("pre_reset_cnt5", 5, 5, 38'h34, 1);
    do_reset(1'b1);
    check("reset_drops_push", 0, 0, 38'h0, 0);
    drive(0,0,1, 38'h0, 3,3);
    check("entries_cleared", 3, 3, 38'h0, 1);
    drive_idle();

    // random traffic against the reference model
    do_reset(1'b0);
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      r_rst  = ($urandom_range(0, 99) == 0);
      r_push = ($urandom_range(0, 99) < 45);
      r_pop  = ($urandom_range(0, 99) < 40);
      r_rest = ($urandom_range(0, 99) < 5);
      r_pc   = {$urandom_range(0, 63), $urandom};
      r_ridx = $urandom_range(0, 15);
      r_rcnt = $urandom_range(0, 31);
      model_step(r_rst, r_push, r_pop, r_rest, r_pc, r_ridx, r_rcnt);
      exp_q.push_back({ras_idx_t'(m_idx), ras_cnt_t'(m_cnt), m_mem[m_idx], (m_cnt != 0)});
      rst = r_rst;
      drive(r_push, r_pop, r_rest, r_pc, ras_idx_t'(r_ridx), ras_cnt_t'(r_rcnt));
      rst = 1'b0;
      exp_w = exp_q.pop_front();
      check("random", exp_w[47:44], exp_w[43:39], exp_w[38:1], exp_w[0]);
    end
    drive_idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
